bomb_slot_arbiter: RTL and testbench

- Shared pool of bomb slots for both players: arbitrates placement requests, allocates free slots and sequences each slot through fuse and blast phases.
- Sits between the per-player debounced bomb buttons/position logic and the renderer/collision logic.
- Consumes a 1 ms tick strobe.
- Outputs packed slot coordinates and per-slot phase flags.

---
 rtl/bomb_slot_arbiter_pkg.sv | 20 ++
 rtl/bomb_slot.sv | 100 ++++++++++
 rtl/bomb_slot_arbiter.sv | 155 +++++++++++++++
 tb/tb_bomb_slot_arbiter.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/bomb_slot_arbiter_pkg.sv
// bomb_pkg: shared types and defaults for the bomb slot pool.
//   slot_state_t  : per-slot phase encoding
//   DEF_*         : default timing / coordinate width
//   PLAYER1/2     : owner id encoding used on slot_owner
package bomb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FUSE  = 2'd1,
    BLAST = 2'd2
  } slot_state_t;

  localparam int DEF_FUSE_MS  = 3000;
  localparam int DEF_BLAST_MS = 1000;
  localparam int DEF_COORD_W  = 6;

  localparam logic PLAYER1 = 1'b0;
  localparam logic PLAYER2 = 1'b1;

endpackage

// File: rtl/bomb_slot.sv
// bomb_slot: one bomb slot -- phase FSM, ms counter, position/owner regs.
//   clk, rst_n          : clock, async active-low reset
//   tick                : 1 ms strobe
//   alloc, alloc_x/y/owner : load a new bomb (honoured only in IDLE)
//   detonate            : early blast request (honoured only in FUSE)
//   x, y, owner         : held position/owner, zero while IDLE
//   fuse, blast         : phase flags
//   blast_start         : one-cycle pulse on FUSE->BLAST
module bomb_slot
  import bomb_pkg::*;
#(
  parameter int FUSE_MS  = DEF_FUSE_MS,
  parameter int BLAST_MS = DEF_BLAST_MS,
  parameter int COORD_W  = DEF_COORD_W,
  parameter int CNT_W    = 13
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick,
  input  logic               alloc,
  input  logic [COORD_W-1:0] alloc_x,
  input  logic [COORD_W-1:0] alloc_y,
  input  logic               alloc_owner,
  input  logic               detonate,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               owner,
  output logic               fuse,
  output logic               blast,
  output logic               blast_start
);

  slot_state_t        state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [COORD_W-1:0] x_d, y_d;
  logic               own_d, bs_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      x           <= '0;
      y           <= '0;
      owner       <= 1'b0;
      blast_start <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      x           <= x_d;
      y           <= y_d;
      owner       <= own_d;
      blast_start <= bs_d;
    end
  end

  // Phase changes fire on the tick that finds the counter at 1; "<= 1"
  // also covers a zero count so a slot can never get stuck.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x;
    y_d     = y;
    own_d   = owner;
    bs_d    = 1'b0;
    case (state_q)
      IDLE: if (alloc) begin
        state_d = FUSE;
        cnt_d   = CNT_W'(FUSE_MS);
        x_d     = alloc_x;
        y_d     = alloc_y;
        own_d   = alloc_owner;
      end
      FUSE: begin
        if (detonate || (tick && cnt_q <= CNT_W'(1))) begin
          state_d = BLAST;
          cnt_d   = CNT_W'(BLAST_MS);
          bs_d    = 1'b1;
        end else if (tick) begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      BLAST: begin
        if (tick && cnt_q <= CNT_W'(1)) begin
          state_d = IDLE;
          cnt_d   = '0;
          x_d     = '0;
          y_d     = '0;
          own_d   = 1'b0;
        end else if (tick) begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign fuse  = (state_q == FUSE);
  assign blast = (state_q == BLAST);

endmodule

// File: rtl/bomb_slot_arbiter.sv
// bomb_slot_arbiter: shared bomb slot pool for two players.
//   clk, rst_n             : clock, async active-low reset
//   tick_1ms               : 1 ms strobe
//   req_p1/2, p1/2_x/y     : placement request pulse + grid position
//   detonate[SLOTS]        : chain-reaction blast request per slot
//   grant_p1/2, deny_p1/2  : registered response, one cycle after request
//   slot_x/y               : packed positions, slot i at [i*COORD_W +: COORD_W]
//   slot_owner             : 0 = player 1, 1 = player 2
//   slot_fuse/blast        : phase flags; blast_start pulses on blast entry
module bomb_slot_arbiter
  import bomb_pkg::*;
#(
  parameter int SLOTS          = 6,
  parameter int PER_PLAYER_MAX = 3,
  parameter int FUSE_MS        = DEF_FUSE_MS,
  parameter int BLAST_MS       = DEF_BLAST_MS,
  parameter int COORD_W        = DEF_COORD_W,
  parameter int CNT_W          = 13
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     tick_1ms,
  input  logic                     req_p1,
  input  logic                     req_p2,
  input  logic [COORD_W-1:0]       p1_x,
  input  logic [COORD_W-1:0]       p1_y,
  input  logic [COORD_W-1:0]       p2_x,
  input  logic [COORD_W-1:0]       p2_y,
  input  logic [SLOTS-1:0]         detonate,
  output logic                     grant_p1,
  output logic                     grant_p2,
  output logic                     deny_p1,
  output logic                     deny_p2,
  output logic [SLOTS*COORD_W-1:0] slot_x,
  output logic [SLOTS*COORD_W-1:0] slot_y,
  output logic [SLOTS-1:0]         slot_owner,
  output logic [SLOTS-1:0]         slot_fuse,
  output logic [SLOTS-1:0]         slot_blast,
  output logic [SLOTS-1:0]         blast_start
);

  localparam int IW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int CW = $clog2(SLOTS + 1) + 1;

  logic [SLOTS-1:0][COORD_W-1:0] sx, sy;
  logic [SLOTS-1:0]              live;
  logic                          rr_q;   // 0: player 1 wins ties

  logic [CW-1:0] p1_cnt, p2_cnt;
  logic          p1_hit, p2_hit, have1, have2, ok1, ok2, same, g1, g2;
  logic [IW-1:0] idx1, idx2, s1, s2;

  assign slot_x = sx;
  assign slot_y = sy;
  assign live   = slot_fuse | slot_blast;

  // Quota, occupancy and the two lowest free slots, all from registered
  // slot state, so a slot freed this edge is only reusable next cycle.
  always_comb begin
    p1_cnt = '0;
    p2_cnt = '0;
    p1_hit = 1'b0;
    p2_hit = 1'b0;
    have1  = 1'b0;
    have2  = 1'b0;
    idx1   = '0;
    idx2   = '0;
    for (int i = 0; i < SLOTS; i++) begin
      if (live[i]) begin
        if (slot_owner[i] == PLAYER2) p2_cnt = p2_cnt + CW'(1);
        else                          p1_cnt = p1_cnt + CW'(1);
        if (sx[i] == p1_x && sy[i] == p1_y) p1_hit = 1'b1;
        if (sx[i] == p2_x && sy[i] == p2_y) p2_hit = 1'b1;
      end else if (!have1) begin
        have1 = 1'b1;
        idx1  = IW'(i);
      end else if (!have2) begin
        have2 = 1'b1;
        idx2  = IW'(i);
      end
    end
  end

  // The winner of a simultaneous request takes the lowest free slot; the
  // loser needs a second slot and a distinct position. If the winner is
  // rejected on its own terms the loser is judged as if alone.
  always_comb begin
    ok1  = (p1_cnt < CW'(PER_PLAYER_MAX)) && !p1_hit && have1;
    ok2  = (p2_cnt < CW'(PER_PLAYER_MAX)) && !p2_hit && have1;
    same = (p1_x == p2_x) && (p1_y == p2_y);
    g1   = 1'b0;
    g2   = 1'b0;
    s1   = idx1;
    s2   = idx1;
    if (req_p1 && req_p2) begin
      if (rr_q == PLAYER1) begin
        g1 = ok1;
        g2 = ok1 ? (ok2 && have2 && !same) : ok2;
        if (ok1) s2 = idx2;
      end else begin
        g2 = ok2;
        g1 = ok2 ? (ok1 && have2 && !same) : ok1;
        if (ok2) s1 = idx2;
      end
    end else begin
      g1 = req_p1 && ok1;
      g2 = req_p2 && ok2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q     <= PLAYER1;
      grant_p1 <= 1'b0;
      grant_p2 <= 1'b0;
      deny_p1  <= 1'b0;
      deny_p2  <= 1'b0;
    end else begin
      if (req_p1 && req_p2) rr_q <= ~rr_q;
      grant_p1 <= g1;
      grant_p2 <= g2;
      deny_p1  <= req_p1 && !g1;
      deny_p2  <= req_p2 && !g2;
    end
  end

  for (genvar i = 0; i < SLOTS; i++) begin : g_slot
    logic pick1, pick2;
    assign pick1 = g1 && (s1 == IW'(i));
    assign pick2 = g2 && (s2 == IW'(i));

    bomb_slot #(
      .FUSE_MS (FUSE_MS),
      .BLAST_MS(BLAST_MS),
      .COORD_W (COORD_W),
      .CNT_W   (CNT_W)
    ) u_slot (
      .clk        (clk),
      .rst_n      (rst_n),
      .tick       (tick_1ms),
      .alloc      (pick1 | pick2),
      .alloc_x    (pick2 ? p2_x : p1_x),
      .alloc_y    (pick2 ? p2_y : p1_y),
      .alloc_owner(pick2),
      .detonate   (detonate[i]),
      .x          (sx[i]),
      .y          (sy[i]),
      .owner      (slot_owner[i]),
      .fuse       (slot_fuse[i]),
      .blast      (slot_blast[i]),
      .blast_start(blast_start[i])
    );
  end

endmodule

// File: tb/tb_bomb_slot_arbiter.sv
module tb_bomb_slot_arbiter;
  localparam int SLOTS = 4;
  localparam int W     = 6;

  logic             clk = 1'b0;
  logic             rst_n, tick_1ms, req_p1, req_p2;
  logic [W-1:0]     p1_x, p1_y, p2_x, p2_y;
  logic [SLOTS-1:0] detonate;
  logic             grant_p1, grant_p2, deny_p1, deny_p2;
  logic [SLOTS*W-1:0] slot_x, slot_y;
  logic [SLOTS-1:0] slot_owner, slot_fuse, slot_blast, blast_start;

  int checks = 0;
  int fails  = 0;

  bomb_slot_arbiter #(
    .SLOTS(SLOTS), .PER_PLAYER_MAX(2), .FUSE_MS(5), .BLAST_MS(3),
    .COORD_W(W), .CNT_W(13)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tick_1ms(tick_1ms),
    .req_p1(req_p1), .req_p2(req_p2),
    .p1_x(p1_x), .p1_y(p1_y), .p2_x(p2_x), .p2_y(p2_y),
    .detonate(detonate),
    .grant_p1(grant_p1), .grant_p2(grant_p2),
    .deny_p1(deny_p1), .deny_p2(deny_p2),
    .slot_x(slot_x), .slot_y(slot_y), .slot_owner(slot_owner),
    .slot_fuse(slot_fuse), .slot_blast(slot_blast), .blast_start(blast_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      tick_1ms = 1'b1;
      step();
      tick_1ms = 1'b0;
    end
  endtask

  task automatic req(input logic r1, input logic [W-1:0] x1, input logic [W-1:0] y1,
                     input logic r2, input logic [W-1:0] x2, input logic [W-1:0] y2);
    req_p1 = r1; p1_x = x1; p1_y = y1;
    req_p2 = r2; p2_x = x2; p2_y = y2;
    step();
    req_p1 = 1'b0;
    req_p2 = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    rst_n = 1'b0; tick_1ms = 1'b0; req_p1 = 1'b0; req_p2 = 1'b0;
    p1_x = '0; p1_y = '0; p2_x = '0; p2_y = '0; detonate = '0;
    #2;
    chk("rst_fuse",  slot_fuse,  0);
    chk("rst_blast", slot_blast, 0);
    chk("rst_resp",  {grant_p1, grant_p2, deny_p1, deny_p2}, 0);
    chk("rst_xy",    {slot_x, slot_y}, 0);
    step(); step();
    rst_n = 1'b1;
    step();

    // single placement, full fuse and blast timing
    req(1, 3, 4, 0, 0, 0);
    chk("single_grant", {grant_p1, deny_p1}, 2'b10);
    chk("single_fuse",  slot_fuse, 4'b0001);
    chk("single_x",     slot_x[0 +: W], 3);
    chk("single_y",     slot_y[0 +: W], 4);
    chk("single_own",   slot_owner, 0);
    step();
    chk("grant_pulse",  grant_p1, 0);
    ticks(4);
    chk("fuse_4ticks",  {slot_fuse, slot_blast, blast_start}, {4'b0001, 4'b0000, 4'b0000});
    ticks(1);
    chk("bs_5th_tick",  {slot_fuse, slot_blast, blast_start}, {4'b0000, 4'b0001, 4'b0001});
    step();
    chk("bs_pulse",     blast_start, 0);
    ticks(2);
    chk("blast_2ticks", slot_blast, 4'b0001);
    ticks(1);
    chk("blast_done",   {slot_fuse, slot_blast}, 0);
    chk("cleared_xy",   {slot_x[0 +: W], slot_y[0 +: W]}, 0);

    // quota
    do_reset();
    req(1, 1, 1, 0, 0, 0);
    req(1, 2, 2, 0, 0, 0);
    chk("quota_2nd",    {grant_p1, deny_p1}, 2'b10);
    req(1, 3, 3, 0, 0, 0);
    chk("quota_deny",   {grant_p1, deny_p1}, 2'b01);
    chk("quota_live",   slot_fuse, 4'b0011);
    detonate = 4'b0001;
    step();
    detonate = '0;
    ticks(3);
    chk("quota_freed",  {slot_fuse, slot_blast}, {4'b0010, 4'b0000});
    req(1, 3, 3, 0, 0, 0);
    chk("quota_regrant", {grant_p1, deny_p1}, 2'b10);
    chk("quota_slot0",  {slot_fuse, slot_x[0 +: W]}, {4'b0011, 6'd3});

    // simultaneous requests, pointer toggle
    do_reset();
    req(1, 1, 2, 1, 7, 8);
    chk("sim1_grants",  {grant_p1, grant_p2, deny_p1, deny_p2}, 4'b1100);
    chk("sim1_xs",      {slot_x[1*W +: W], slot_x[0 +: W]}, {6'd7, 6'd1});
    chk("sim1_own",     slot_owner, 4'b0010);
    req(1, 3, 3, 1, 9, 9);
    chk("sim2_grants",  {grant_p1, grant_p2}, 2'b11);
    chk("sim2_xs",      {slot_x[3*W +: W], slot_x[2*W +: W]}, {6'd3, 6'd9});
    chk("sim2_own",     {slot_owner, slot_fuse}, {4'b0110, 4'b1111});

    // same-coordinate collision
    do_reset();
    req(1, 5, 5, 1, 5, 5);
    chk("coll_resp",    {grant_p1, grant_p2, deny_p1, deny_p2}, 4'b1001);
    chk("coll_fuse",    slot_fuse, 4'b0001);
    req(0, 0, 0, 1, 5, 5);
    chk("coll_later",   {grant_p2, deny_p2}, 2'b01);
    req(1, 6, 6, 1, 7, 7);
    chk("coll_rr",      {slot_owner, slot_x[1*W +: W], slot_x[2*W +: W]}, {4'b0010, 6'd7, 6'd6});

    // chain detonation; idle slot ignores detonate
    do_reset();
    req(1, 1, 1, 0, 0, 0);
    req(0, 0, 0, 1, 2, 2);
    ticks(1);
    detonate = 4'b1010;
    step();
    detonate = '0;
    chk("chain_bs",     {blast_start, slot_blast, slot_fuse}, {4'b0010, 4'b0010, 4'b0001});
    step();
    chk("chain_pulse",  blast_start, 0);
    ticks(2);
    chk("chain_2ticks", slot_blast, 4'b0010);
    ticks(1);
    chk("chain_done",   {slot_blast, slot_fuse}, {4'b0000, 4'b0001});

    // async reset mid-blast
    detonate = 4'b0001;
    step();
    detonate = '0;
    chk("pre_rst_blast", slot_blast, 4'b0001);
    rst_n = 1'b0;
    #2;
    chk("async_rst",    {slot_blast, slot_fuse, blast_start}, 0);
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_bs",  blast_start, 0);
    req(0, 0, 0, 1, 4, 4);
    chk("post_rst_req", {grant_p2, slot_fuse, slot_owner}, {1'b1, 4'b0001, 4'b0001});

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
